// File: rtl/banco_registradores_param.sv
// Parametrised register file: two registered read ports (A with immediate override),
// one write port, optional bypass/zero register, and a sequenced clear engine.
module banco_registradores_param #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter bit          ZERO_REG = 1'b0,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr_c,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clear,
  output logic              busy,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic              out_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [0:0]        state, state_nxt;
  logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;
  logic [DATA_W-1:0] out_a_nxt, out_b_nxt;
  logic              out_valid_nxt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] val_a, val_b;

  // Read value with zero-register and write-forwarding priority
  always_comb begin
    val_a = mem[addr_a];
    if (ZERO_REG && (addr_a == '0))
      val_a = '0;
    else if (BYPASS && wr_en && (addr_c == addr_a))
      val_a = wr_data;
  end

  always_comb begin
    val_b = mem[addr_b];
    if (ZERO_REG && (addr_b == '0))
      val_b = '0;
    else if (BYPASS && wr_en && (addr_c == addr_b))
      val_b = wr_data;
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt     = state;
    clr_idx_nxt   = clr_idx;
    out_a_nxt     = out_a;
    out_b_nxt     = out_b;
    out_valid_nxt = 1'b0;
    mem_we        = 1'b0;
    mem_waddr     = addr_c;
    mem_wdata     = wr_data;

    case (state)
      S_CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clr_idx;
        mem_wdata   = '0;
        clr_idx_nxt = clr_idx + ADDR_W'(1);
        if (clr_idx == ADDR_W'(DEPTH - 1))
          state_nxt = S_IDLE;
      end
      default: begin
        if (clear) begin
          state_nxt   = S_CLEAR;
          clr_idx_nxt = '0;
        end else begin
          mem_we = wr_en && !(ZERO_REG && (addr_c == '0));
          if (rd_en) begin
            out_a_nxt     = use_imm ? imm : val_a;
            out_b_nxt     = val_b;
            out_valid_nxt = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_CLEAR;
      clr_idx   <= '0;
      busy      <= 1'b1;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      clr_idx   <= clr_idx_nxt;
      busy      <= (state_nxt == S_CLEAR);
      out_a     <= out_a_nxt;
      out_b     <= out_b_nxt;
      out_valid <= out_valid_nxt;
    end
  end

  // Storage array carries no reset; the clear engine initialises it
  always_ff @(posedge clk) begin
    if (!rst && mem_we)
      mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_banco_registradores_param.sv
// Bench: two register-file configurations driven in parallel, checked every cycle
// against a behavioural model plus directed literal expectations.
module tb_banco_registradores_param;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst, rd_en, use_imm, wr_en, clear;
  logic [3:0]  addr_a, addr_b, addr_c;
  logic [15:0] imm, wr_data;

  logic        dbusy  [2];
  logic        dvalid [2];
  logic [15:0] da     [2];
  logic [15:0] db     [2];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // dut0: no zero register, bypass on; dut1: zero register, bypass off
  banco_registradores_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b0), .BYPASS(1'b1)) dut0 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b), .imm(imm),
    .use_imm(use_imm), .wr_en(wr_en), .addr_c(addr_c), .wr_data(wr_data), .clear(clear),
    .busy(dbusy[0]), .out_a(da[0]), .out_b(db[0]), .out_valid(dvalid[0]));

  banco_registradores_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .addr_a(addr_a), .addr_b(addr_b), .imm(imm),
    .use_imm(use_imm), .wr_en(wr_en), .addr_c(addr_c), .wr_data(wr_data), .clear(clear),
    .busy(dbusy[1]), .out_a(da[1]), .out_b(db[1]), .out_valid(dvalid[1]));

  // Behavioural model state
  bit          zr [2] = '{1'b0, 1'b1};
  bit          bp [2] = '{1'b1, 1'b0};
  logic [15:0] mm [2][DEPTH];
  int          left [2] = '{0, 0};
  logic [15:0] ea [2];
  logic [15:0] eb [2];
  logic        ev [2];
  bit          started = 1'b0;

  function automatic logic [15:0] model_val(int k, logic [3:0] x);
    if (zr[k] && x == 4'd0) return 16'h0000;
    if (bp[k] && wr_en && addr_c == x) return wr_data;
    return mm[k][x];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        started = 1'b1;
        left[k] = DEPTH;
        ea[k] = 16'h0000; eb[k] = 16'h0000; ev[k] = 1'b0;
        for (int j = 0; j < DEPTH; j++) mm[k][j] = 16'h0000;
      end else if (left[k] > 0) begin
        left[k] = left[k] - 1;
        ev[k] = 1'b0;
      end else if (clear) begin
        left[k] = DEPTH;
        ev[k] = 1'b0;
        for (int j = 0; j < DEPTH; j++) mm[k][j] = 16'h0000;
      end else begin
        if (rd_en) begin
          ea[k] = use_imm ? imm : model_val(k, addr_a);
          eb[k] = model_val(k, addr_b);
        end
        ev[k] = rd_en;
        if (wr_en && !(zr[k] && addr_c == 4'd0)) mm[k][addr_c] = wr_data;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy%0d", k),  32'(dbusy[k]),  32'(left[k] > 0));
        chk($sformatf("valid%0d", k), 32'(dvalid[k]), 32'(ev[k]));
        chk($sformatf("out_a%0d", k), 32'(da[k]),     32'(ea[k]));
        chk($sformatf("out_b%0d", k), 32'(db[k]),     32'(eb[k]));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 40 && dbusy[0]; i++) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; addr_c = a; wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; rd_en = 1'b0; use_imm = 1'b0; wr_en = 1'b0; clear = 1'b0;
    addr_a = '0; addr_b = '0; addr_c = '0; imm = '0; wr_data = '0;
    cyc();
    rst = 1'b0;

    // Reset clear with a write attempted while busy
    chk("rst_out_a", 32'(da[0]), 32'h0);
    wr_en = 1'b1; addr_c = 4'd3; wr_data = 16'hBEEF;
    count_busy(n);
    chk("rst_busy_len", 32'(n), 32'd16);
    wr_en = 1'b0;
    rd_en = 1'b1; addr_a = 4'd3;
    cyc();
    rd_en = 1'b0;
    chk("rst_r3_a", 32'(da[0]), 32'h0);
    chk("rst_r3_v", 32'(dvalid[0]), 32'h1);

    // Write then read
    wr(4'd5, 16'h1234);
    wr(4'd9, 16'hABCD);
    rd_en = 1'b1; addr_a = 4'd5; addr_b = 4'd9;
    cyc();
    rd_en = 1'b0;
    chk("wr_rd_a", 32'(da[1]), 32'h1234);
    chk("wr_rd_b", 32'(db[1]), 32'hABCD);
    chk("wr_rd_v", 32'(dvalid[1]), 32'h1);
    cyc();
    chk("wr_rd_v_drop", 32'(dvalid[1]), 32'h0);

    // Bypass versus old-value read
    wr(4'd7, 16'h0001);
    wr_en = 1'b1; addr_c = 4'd7; wr_data = 16'h00FF;
    rd_en = 1'b1; addr_a = 4'd7; addr_b = 4'd7;
    cyc();
    wr_en = 1'b0;
    chk("byp_on_a", 32'(da[0]), 32'h00FF);
    chk("byp_on_b", 32'(db[0]), 32'h00FF);
    chk("byp_off_a", 32'(da[1]), 32'h0001);
    chk("byp_off_b", 32'(db[1]), 32'h0001);
    cyc();
    rd_en = 1'b0;
    chk("byp_off_next", 32'(da[1]), 32'h00FF);

    // Immediate and zero register
    wr(4'd0, 16'h5555);
    rd_en = 1'b1; use_imm = 1'b1; imm = 16'h7FFF; addr_a = 4'd2; addr_b = 4'd0;
    cyc();
    rd_en = 1'b0; use_imm = 1'b0;
    chk("imm_a1", 32'(da[1]), 32'h7FFF);
    chk("zero_b1", 32'(db[1]), 32'h0000);
    chk("imm_a0", 32'(da[0]), 32'h7FFF);
    chk("r0_b0", 32'(db[0]), 32'h5555);

    // Clear request beats a same-cycle write and read
    wr(4'd4, 16'h4444);
    clear = 1'b1; wr_en = 1'b1; addr_c = 4'd4; wr_data = 16'h9999; rd_en = 1'b1; addr_a = 4'd4;
    cyc();
    clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("clr_valid", 32'(dvalid[0]), 32'h0);
    count_busy(n);
    chk("clr_busy_len", 32'(n), 32'd16);
    rd_en = 1'b1; addr_a = 4'd4; addr_b = 4'd5;
    cyc();
    rd_en = 1'b0;
    chk("clr_r4", 32'(da[0]), 32'h0);
    chk("clr_r5", 32'(db[1]), 32'h0);

    // Reset at clear cycle 8 restarts the sequence
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    repeat (7) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    count_busy(n);
    chk("rst_mid_busy_len", 32'(n), 32'd16);

    // Streaming reads then hold
    wr(4'd1, 16'd1);
    wr(4'd2, 16'd2);
    wr(4'd3, 16'd3);
    rd_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      addr_a = 4'(i);
      cyc();
      chk($sformatf("stream_a%0d", i), 32'(da[0]), 32'(i));
      chk($sformatf("stream_v%0d", i), 32'(dvalid[0]), 32'h1);
    end
    rd_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("hold_a", 32'(da[1]), 32'd3);
      chk("hold_v", 32'(dvalid[1]), 32'h0);
    end

    // Mixed random traffic checked by the model
    for (int i = 0; i < 200; i++) begin
      rd_en   = 1'($urandom);
      wr_en   = 1'($urandom);
      use_imm = ($urandom_range(0, 3) == 0);
      clear   = ($urandom_range(0, 59) == 0);
      addr_a  = 4'($urandom); addr_b = 4'($urandom); addr_c = 4'($urandom);
      imm     = 16'($urandom); wr_data = 16'($urandom);
      cyc();
    end
    rd_en = 1'b0; wr_en = 1'b0; clear = 1'b0; use_imm = 1'b0;
    count_busy(n);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/banco_registradores_param.md
Name: banco_registradores_param

Overview:
- Parametrised successor to the 16x16 datapath register file: configurable data width and depth.
- Two registered read ports; port A has an immediate override. One write port.
- Read and write are independent in the same cycle (no shared RW select), with optional write-to-read bypass and an optional hardwired zero register.
- Adds a sequenced clear engine (on reset or on request) with a busy flag, and a read-valid strobe; sits between decode/writeback and the ALU operand latches.

Parameters:
- DATA_W, 16, width of each register, immediate and data path.
- ADDR_W, 4, register address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 0, if 1, entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, if 1, a same-cycle write to a read address forwards wr_data to the read output; if 0, the old value is read.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_en  in  1  capture read ports this cycle.
- addr_a  in  ADDR_W  read address, port A.
- addr_b  in  ADDR_W  read address, port B.
- imm  in  DATA_W  immediate operand.
- use_imm  in  1  1: port A returns imm instead of reg[addr_a].
- wr_en  in  1  write enable.
- addr_c  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- clear  in  1  request full register clear (pulse).
- busy  out  1  1 while the clear engine runs; reads and writes are ignored.
- out_a  out  DATA_W  registered read result, port A.
- out_b  out  DATA_W  registered read result, port B.
- out_valid  out  1  1-cycle strobe: out_a/out_b updated by the read issued last cycle.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- States: IDLE, CLEAR. A counter clr_idx of width ADDR_W.
- Reset (rst=1 at an edge):
  - out_a=0, out_b=0, out_valid=0, clr_idx=0, state=CLEAR, busy=1 on the next cycle.
  - rst has priority over everything.
  - rst asserted mid-clear restarts clr_idx at 0.
- CLEAR state:
  - Each cycle writes 0 to reg[clr_idx] and increments clr_idx.
  - When clr_idx==DEPTH-1 is written, go to IDLE; busy deasserts the following cycle.
  - Total busy duration = DEPTH cycles (16 at default).
  - rd_en, wr_en and clear are ignored; out_valid=0; out_a/out_b hold.
- IDLE, clear=1:
  - Enter CLEAR with clr_idx=0.
  - A wr_en or rd_en in the same cycle is dropped (clear wins).
- IDLE, write: when wr_en=1, reg[addr_c]<=wr_data at the edge, except addr_c==0 with ZERO_REG=1, which is discarded.
- IDLE, read:
  - When rd_en=1, at the edge: out_a <= use_imm ? imm : value(addr_a), and out_b <= value(addr_b).
  - out_valid=1 for exactly the next cycle.
  - Read latency is 1 cycle.
- value(x), evaluated in priority order:
  - If ZERO_REG=1 and x==0: 0.
  - Else if BYPASS=1, wr_en=1 and addr_c==x: wr_data.
  - Else reg[x] (pre-write contents).
- rd_en=0: out_a/out_b hold their last value; out_valid=0.
- Back-to-back reads on consecutive cycles: out_valid stays high continuously, and each cycle reflects the prior cycle's request.
- Width rules: all data is DATA_W bits with no extension or truncation. Addresses are full-range, so no out-of-range case exists.
- Register array contents are defined only after the first clear completes. The bench does not check reads before busy first falls.

Test Plan:
- Reset clear:
  - Stimulus: pulse rst; during busy, drive wr_en=1 addr_c=3 wr_data=16'hBEEF.
  - Response: busy=1 for exactly 16 cycles; then a read of addr_a=3 gives out_a=0 and out_valid=1 one cycle after rd_en.
- Write then read:
  - Stimulus: write 16'h1234 to r5 and 16'hABCD to r9; next cycle rd_en with addr_a=5, addr_b=9.
  - Response: out_a=16'h1234, out_b=16'hABCD, out_valid high for 1 cycle.
- Bypass:
  - Stimulus: r7=16'h0001; in the same cycle wr_en addr_c=7 wr_data=16'h00FF with rd_en addr_a=7, addr_b=7.
  - Response with BYPASS=1: out_a=out_b=16'h00FF.
  - Response with BYPASS=0: out_a=out_b=16'h0001, and a next-cycle read gives 16'h00FF.
- Immediate and zero register:
  - Stimulus (ZERO_REG=1): write 16'h5555 to r0; then rd_en use_imm=1 imm=16'h7FFF addr_a=2, addr_b=0.
  - Response: out_a=16'h7FFF, out_b=0.
- Clear request mid-operation:
  - Stimulus: r4=16'h4444; assert clear with wr_en addr_c=4 wr_data=16'h9999 in the same cycle.
  - Response: busy for 16 cycles; a read of r4 afterwards gives 0.
  - Variant: rst at clear cycle 8 restarts the sequence, giving 16 more busy cycles.
- Hold and streaming:
  - Stimulus: three consecutive rd_en cycles to r1, r2, r3 (values 1, 2, 3), then rd_en=0 for 2 cycles.
  - Response: out_a sequence 1, 2, 3; out_valid high 3 cycles, then low; out_a holds 3.
